// File: rtl/fetch_sequencer.sv
// Fetch-unit controller: drives en_pc/en_new_pc/new_pc and turns the fetch
// unit's registered instruction into a valid/ready stream tagged with its PC.
module fetch_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              out_ready,
    input  logic [15:0]       fu_instruction,
    output logic              en_pc,
    output logic              en_new_pc,
    output logic [ADDR_W-1:0] new_pc,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  accepted_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_REDIRECT,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] target;
    logic              halt_pending;
    logic              accept;

    assign accept = instr_valid & out_ready;
    assign instr  = fu_instruction;

    always_comb begin
        state_next = state;
        en_pc      = 1'b0;
        en_new_pc  = 1'b0;
        new_pc     = '0;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                en_pc = !branch_valid && !halt_pending && (!instr_valid || out_ready);
                if (branch_valid)  state_next = S_REDIRECT;
                else if (halt_req) state_next = S_DRAIN;
            end
            S_REDIRECT: begin
                en_new_pc  = 1'b1;
                new_pc     = target;
                state_next = (halt_pending || halt_req) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                if (!instr_valid) state_next = S_HALTED;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Later assignments override the fetch/accept update: a redirect flushes
    // whatever is held, and REDIRECT squashes the stale word the fetch unit emits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc     <= '0;
            target       <= '0;
            halt_pending <= 1'b0;
            instr_valid  <= 1'b0;
            instr_pc     <= '0;
        end else begin
            if (en_pc) begin
                instr_valid <= 1'b1;
                instr_pc    <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(1);
            end else if (accept) begin
                instr_valid <= 1'b0;
            end

            if (state == S_RUN && branch_valid) begin
                instr_valid <= 1'b0;
                target      <= branch_target;
                if (halt_req) halt_pending <= 1'b1;
            end else if (state == S_RUN && halt_req) begin
                halt_pending <= 1'b1;
            end

            if (state == S_REDIRECT) begin
                instr_valid <= 1'b0;
                fetch_pc    <= target;
                if (halt_req) halt_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            accepted_count <= '0;
        else if (accept && accepted_count != '1)
            accepted_count <= accepted_count + CNT_W'(1);
    end

endmodule
